// File: rtl/noise_table_loader.sv
// Noise table loader: copies NUM_WORDS words from a synchronous table ROM into the
// noise wrapper over its location/mem_data/load_mem interface, then waits for
// done_wait (bounded by TIMEOUT cycles) before reporting completion.
// Optional: define NOISE_LOADER_CHECKSUM_EN to add a running XOR checksum output.
module noise_table_loader #(
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_WORDS = 15,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_rdata,
    output logic [ADDR_W-1:0] location,
    output logic [WORD_W-1:0] mem_data,
    output logic              load_mem,
    input  logic              done_wait,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
`ifdef NOISE_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] checksum
`endif
);

    localparam int unsigned       TcntW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LastK = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWrite, StWaitAck, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] location_q, location_d;
    logic [WORD_W-1:0] mem_data_q, mem_data_d;
    logic              load_mem_q, load_mem_d;
    logic              err_q, err_d;
    logic [TcntW-1:0]  tcnt_q, tcnt_d, tcnt_inc;
    logic              start_ok;
    logic              tmo_hit;

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    // Saturating increment so the counter can never wrap back below TIMEOUT
    assign tcnt_inc = (tcnt_q == {TcntW{1'b1}}) ? tcnt_q : tcnt_q + 1'b1;
    assign tmo_hit  = 32'(tcnt_inc) >= TIMEOUT;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; done_wait only matters while waiting for the ack
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start_ok) state_d = StFetch;
            StFetch:        state_d = StWrite;
            StWrite:        state_d = (k_q == LastK) ? StWaitAck : StFetch;
            StWaitAck: begin
                if (done_wait || tmo_hit) state_d = StDone;
            end
            default:        state_d = StIdle;
        endcase
    end

    // Datapath next values; location/mem_data only move in WRITE so they hold otherwise
    always_comb begin
        k_d        = k_q;
        rom_addr_d = rom_addr_q;
        location_d = location_q;
        mem_data_d = mem_data_q;
        load_mem_d = 1'b0;
        err_d      = err_q;
        tcnt_d     = tcnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    k_d        = '0;
                    rom_addr_d = '0;
                    err_d      = 1'b0;
                    tcnt_d     = '0;
                end
            end
            StWrite: begin
                mem_data_d = rom_rdata;
                location_d = k_q;
                load_mem_d = 1'b1;
                if (k_q == LastK) begin
                    tcnt_d = '0;
                end else begin
                    k_d        = k_q + 1'b1;
                    rom_addr_d = k_q + 1'b1;
                end
            end
            StWaitAck: begin
                tcnt_d = tcnt_inc;
                if (!done_wait && tmo_hit) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            rom_addr_q <= '0;
            location_q <= '0;
            mem_data_q <= '0;
            load_mem_q <= 1'b0;
            err_q      <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            k_q        <= k_d;
            rom_addr_q <= rom_addr_d;
            location_q <= location_d;
            mem_data_q <= mem_data_d;
            load_mem_q <= load_mem_d;
            err_q      <= err_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StFetch, StWrite, StWaitAck: busy = 1'b1;
            StDone:                      done = 1'b1;
            default: ;
        endcase
    end

    assign rom_addr    = rom_addr_q;
    assign location    = location_q;
    assign mem_data    = mem_data_q;
    assign load_mem    = load_mem_q;
    assign err_timeout = err_q;

`ifdef NOISE_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] checksum_q, checksum_d;

    // Running XOR of every word fetched from the ROM during this load
    always_comb begin
        checksum_d = checksum_q;
        if (start_ok) begin
            checksum_d = '0;
        end else if (state_q == StWrite) begin
            checksum_d = checksum_q ^ rom_rdata;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
